sample_sequencer: RTL and testbench

Sample-rate scheduler for the audio path: ADC capture → processor → DAC/PWM output. It derives the sampling tick from the system clock and starts one ADC conversion per tick. It hands each captured sample to the processor through a valid/done handshake, then commits the result to the DAC and PWM stages with a single start pulse. It sits between the tick source, the SPI ADC/DAC interfaces and the processor, replacing free-running tick fan-out with an ordered, overrun-checked sequence.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/sample_tick_gen.sv | 34 +++
 rtl/sample_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sample_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample path: sequencer state encoding,
// DAC mid-scale (silence) code, default divider/timeout values, and a
// saturating 8-bit increment used by the event counters.
package audio_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_ADC_REQ   = 3'd1,
        SEQ_ADC_WAIT  = 3'd2,
        SEQ_PROC_WAIT = 3'd3,
        SEQ_DAC_REQ   = 3'd4
    } seq_state_t;

    localparam logic [9:0] DAC_MIDSCALE    = 10'h200;
    localparam int         DEFAULT_DIV     = 5000;
    localparam int         DEFAULT_TIMEOUT = 2000;

    // Increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 and wraps; the count is held at 0
// while disabled. o_tick is high for the single cycle where the count sits
// at DIV-1 with the enable present.
module sample_tick_gen #(
    parameter int DIV = 5000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);

    // Divider counter: cleared by reset or while disabled, wraps at DIV-1.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            r_count <= '0;
        end else if (w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = i_enable && w_at_last;

endmodule

// File: rtl/sample_sequencer.sv
// Sample sequencer: one ADC conversion per sample tick, hand-off to the
// processor over a valid/done handshake, then a single DAC/PWM start pulse.
// Ticks arriving while a sequence is in flight are dropped and counted.
//
// Handshakes: adc_start and dac_start are one-cycle pulses. proc_valid is a
// level held with proc_data stable until the cycle proc_done is seen;
// adc_valid / proc_done are only sampled in the state that waits for them.
//
// Optional build macro SEQ_TIMEOUT_EN adds a watchdog on ADC_WAIT and
// PROC_WAIT: after TIMEOUT cycles in either state the sequence is abandoned
// (err_cnt counts it, dac_data is left untouched). Without the macro the FSM
// waits indefinitely and err_cnt reads 0.
module sample_sequencer
    import audio_pkg::*;
#(
    parameter int DIV     = DEFAULT_DIV,
    parameter int DW      = 10,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          enable,
    output logic          adc_start,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    output logic          proc_valid,
    output logic [DW-1:0] proc_data,
    input  logic          proc_done,
    input  logic [DW-1:0] proc_result,
    output logic          dac_start,
    output logic [DW-1:0] dac_data,
    output logic          busy,
    output logic [7:0]    overrun_cnt,
    output logic [7:0]    err_cnt,
    output logic [2:0]    o_dbg_state
);

    if (DIV < 16 || DIV > 65535) begin : g_bad_div
        $error("sample_sequencer: DIV must be within 16..65535");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sample_sequencer: TIMEOUT must be at least 1");
    end

    seq_state_t    r_state;
    seq_state_t    w_state_next;
    logic          w_tick;
    logic          w_timeout;
    logic [DW-1:0] r_proc_data;
    logic [DW-1:0] r_dac_data;
    logic [7:0]    r_overrun_cnt;

    sample_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .i_clk   (sysclk),
        .i_rst   (rst),
        .i_enable(enable),
        .o_tick  (w_tick)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] r_wdog;
    logic [7:0]    r_err_cnt;
    logic          w_waiting;
    logic          w_wd_expired;

    assign w_waiting    = (r_state == SEQ_ADC_WAIT) || (r_state == SEQ_PROC_WAIT);
    assign w_wd_expired = w_waiting && (r_wdog == WW'(TIMEOUT - 1));
    // A completion arriving in the expiry cycle still wins over the timeout.
    assign w_timeout    = w_wd_expired &&
                          !((r_state == SEQ_ADC_WAIT  && adc_valid) ||
                            (r_state == SEQ_PROC_WAIT && proc_done));

    // Watchdog: restarts on every state change, counts while waiting.
    always_ff @(posedge sysclk) begin
        if (rst || (r_state != w_state_next)) begin
            r_wdog <= '0;
        end else if (w_waiting) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Timeout event counter, saturating.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_timeout) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign w_timeout = 1'b0;
    assign err_cnt   = 8'd0;
`endif

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEQ_IDLE:      if (w_tick) w_state_next = SEQ_ADC_REQ;
            SEQ_ADC_REQ:   w_state_next = SEQ_ADC_WAIT;
            SEQ_ADC_WAIT: begin
                if (adc_valid)      w_state_next = SEQ_PROC_WAIT;
                else if (w_timeout) w_state_next = SEQ_IDLE;
            end
            SEQ_PROC_WAIT: begin
                if (proc_done)      w_state_next = SEQ_DAC_REQ;
                else if (w_timeout) w_state_next = SEQ_IDLE;
            end
            SEQ_DAC_REQ:   w_state_next = SEQ_IDLE;
            default:       w_state_next = SEQ_IDLE;
        endcase
    end

    // FSM outputs: pure decodes of the state register.
    always_comb begin
        adc_start   = (r_state == SEQ_ADC_REQ);
        proc_valid  = (r_state == SEQ_PROC_WAIT);
        dac_start   = (r_state == SEQ_DAC_REQ);
        busy        = (r_state != SEQ_IDLE);
        o_dbg_state = r_state;
    end

    // Sample datapath: capture ADC sample, then processed result for the DAC.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_proc_data <= '0;
            r_dac_data  <= DW'(DAC_MIDSCALE);
        end else begin
            if (r_state == SEQ_ADC_WAIT && adc_valid) begin
                r_proc_data <= adc_data;
            end
            if (r_state == SEQ_PROC_WAIT && proc_done) begin
                r_dac_data <= proc_result;
            end
        end
    end

    // Dropped-tick counter, saturating.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_tick && (r_state != SEQ_IDLE)) begin
            r_overrun_cnt <= sat_inc8(r_overrun_cnt);
        end
    end

    assign proc_data   = r_proc_data;
    assign dac_data    = r_dac_data;
    assign overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer with DIV=16. The bench plays the ADC and the
// processor (result = sample ^ 10'h3FF); expected DAC codes come from the
// vector table and are queued when the ADC sample is driven, then popped
// and compared whenever dac_start is seen.
module tb_sample_sequencer;
    import audio_pkg::*;

    localparam int DIV     = 16;
    localparam int DW      = 10;
    localparam int TIMEOUT = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          adc_start;
    logic          adc_valid;
    logic [DW-1:0] adc_data;
    logic          proc_valid;
    logic [DW-1:0] proc_data;
    logic          proc_done;
    logic [DW-1:0] proc_result;
    logic          dac_start;
    logic [DW-1:0] dac_data;
    logic          busy;
    logic [7:0]    overrun_cnt;
    logic [7:0]    err_cnt;
    logic [2:0]    dbg_state;

    sample_sequencer #(
        .DIV(DIV), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .sysclk     (clk),
        .rst        (rst),
        .enable     (enable),
        .adc_start  (adc_start),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .proc_valid (proc_valid),
        .proc_data  (proc_data),
        .proc_done  (proc_done),
        .proc_result(proc_result),
        .dac_start  (dac_start),
        .dac_data   (dac_data),
        .busy       (busy),
        .overrun_cnt(overrun_cnt),
        .err_cnt    (err_cnt),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_hold;
    int            n_adc_pulses = 0;
    int            n_dac_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (adc_start) n_adc_pulses++;
        if (dac_start) begin
            n_dac_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL dac_unexpected: dac_start with dac_data=0x%0h, expected no pulse (cycle %0d)",
                         dac_data, cyc);
            end else begin
                e        = exp_q.pop_front();
                exp_hold = e;
                if (dac_data !== e) begin
                    n_errors++;
                    $display("FAIL dac_data: got 0x%0h expected 0x%0h (cycle %0d)", dac_data, e, cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_for_adc_start(input int budget, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (adc_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL adc_start_wait: no pulse within %0d cycles, required one", budget);
        end
    endtask

    // One full sequence: wait for adc_start, answer after nd cycles, then
    // answer proc_valid after pd cycles. With spur set, a stray proc_done is
    // driven in the first ADC_WAIT cycle (nd must be at least 2).
    task automatic run_seq(input logic [DW-1:0] d, input int nd, input int pd,
                           input logic [DW-1:0] exp_dac, input bit spur,
                           output int waited, output int t_adc);
        bit ok;
        wait_for_adc_start(4 * DIV, waited, ok);
        t_adc = cyc;
        if (!ok) return;
        if (spur) begin
            @(negedge clk);
            proc_done   = 1'b1;
            proc_result = '0;
            @(negedge clk);
            proc_done = 1'b0;
            check("spur_done_state", dbg_state, SEQ_ADC_WAIT);
            check("spur_done_pv", proc_valid, 1'b0);
            check("spur_done_dac", dac_data, exp_hold);
            repeat (nd - 2) @(negedge clk);
        end else begin
            repeat (nd) @(negedge clk);
        end
        adc_valid = 1'b1;
        adc_data  = d;
        exp_q.push_back(exp_dac);
        @(negedge clk);
        adc_valid = 1'b0;
        adc_data  = DW'($urandom_range(0, 1023));
        check("proc_valid_rise", proc_valid, 1'b1);
        check("proc_data", proc_data, d);
        repeat (pd) @(negedge clk);
        if (pd > 0) check("proc_data_stable", {proc_valid, proc_data}, {1'b1, d});
        proc_done   = 1'b1;
        proc_result = d ^ 10'h3FF;
        @(negedge clk);
        proc_done   = 1'b0;
        proc_result = DW'($urandom_range(0, 1023));
        check("dac_start_latency", dac_start, 1'b1);
        check("proc_valid_fall", proc_valid, 1'b0);
    endtask

    task automatic check_reset_values();
        check("rst_adc_start", adc_start, 1'b0);
        check("rst_proc_valid", proc_valid, 1'b0);
        check("rst_proc_data", proc_data, '0);
        check("rst_dac_start", dac_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun_cnt, 8'd0);
        check("rst_err", err_cnt, 8'd0);
        check("rst_dac_data", dac_data, 10'h200);
        check("rst_state", dbg_state, SEQ_IDLE);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [DW-1:0] adc;
        int            nd;
        int            pd;
        logic [DW-1:0] exp_dac;
        int            ovr_inc;
        bit            spur;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        int waited;
        int t_adc;
        int t_prev;
        int exp_ovr;
        int a0;
        int d0;
        bit ok;

        vecs[0] = '{10'h155, 3, 2,  10'h2AA, 0, 1'b0};
        vecs[1] = '{10'h000, 1, 0,  10'h3FF, 0, 1'b0};
        vecs[2] = '{10'h3FF, 2, 1,  10'h000, 0, 1'b0};
        vecs[3] = '{10'h0AB, 3, 20, 10'h354, 1, 1'b0};
        vecs[4] = '{10'h123, 3, 20, 10'h2DC, 1, 1'b0};
        vecs[5] = '{10'h200, 5, 5,  10'h1FF, 0, 1'b0};
        vecs[6] = '{10'h3C3, 3, 1,  10'h03C, 0, 1'b1};

        rst         = 1'b1;
        enable      = 1'b1;
        adc_valid   = 1'b0;
        adc_data    = '0;
        proc_done   = 1'b0;
        proc_result = '0;
        exp_hold    = 10'h200;
        exp_ovr     = 0;
        t_prev      = 0;

        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

`ifdef SEQ_TIMEOUT_EN
        // First tick after reset goes unanswered: watchdog abandons it.
        wait_for_adc_start(4 * DIV, waited, ok);
        check("first_tick", waited, DIV);
        repeat (TIMEOUT) @(negedge clk);
        check("wd_waiting", {busy, err_cnt}, {1'b1, 8'd0});
        @(negedge clk);
        check("wd_state", dbg_state, SEQ_IDLE);
        check("wd_err", err_cnt, 8'd1);
        check("wd_dac_held", dac_data, 10'h200);
        check("wd_pv", proc_valid, 1'b0);
        // ticks at +16, +32, +48 fell inside the 50-cycle wait
        exp_ovr = 3;
        run_seq(10'h155, 3, 2, 10'h2AA, 1'b0, waited, t_adc);
        check("restart_after_timeout", waited, DIV - 3);
        check("wd_overrun", overrun_cnt, exp_ovr);
`else
        run_seq(10'h155, 3, 2, 10'h2AA, 1'b0, waited, t_adc);
        check("first_tick", waited, DIV);
        check("err_tied", err_cnt, 8'd0);
`endif

        // Table: one sequence per row.
        for (int i = 0; i < NV; i++) begin
            run_seq(vecs[i].adc, vecs[i].nd, vecs[i].pd, vecs[i].exp_dac, vecs[i].spur,
                    waited, t_adc);
            exp_ovr += vecs[i].ovr_inc;
            check("overrun_cnt", overrun_cnt, exp_ovr);
            if (i > 0) check("tick_spacing", t_adc - t_prev, DIV * (1 + vecs[i-1].ovr_inc));
            t_prev = t_adc;
        end

        // Enable low for 3 periods, with a stray adc_valid while idle.
        enable = 1'b0;
        @(negedge clk);
        a0 = n_adc_pulses;
        d0 = n_dac_pulses;
        adc_valid = 1'b1;
        adc_data  = 10'h3FF;
        @(negedge clk);
        adc_valid = 1'b0;
        check("spur_valid_busy", busy, 1'b0);
        check("spur_valid_pv", proc_valid, 1'b0);
        check("spur_valid_pdata", proc_data, vecs[NV-1].adc);
        check("spur_valid_dac", dac_data, exp_hold);
        repeat (3 * DIV) @(negedge clk);
        check("disabled_adc_pulses", n_adc_pulses - a0, 0);
        check("disabled_dac_pulses", n_dac_pulses - d0, 0);
        enable = 1'b1;
        run_seq(10'h2F0, 1, 0, 10'h10F, 1'b0, waited, t_adc);
        check("enable_first_tick", waited, DIV);
        check("enable_overrun", overrun_cnt, exp_ovr);

        // Reset while in PROC_WAIT: sample is abandoned, no dac_start.
        wait_for_adc_start(4 * DIV, waited, ok);
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = 10'h0F0;
        @(negedge clk);
        adc_valid = 1'b0;
        check("pre_reset_pv", proc_valid, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst      = 1'b0;
        exp_hold = 10'h200;
        exp_ovr  = 0;
        run_seq(10'h155, 3, 2, 10'h2AA, 1'b0, waited, t_adc);
        check("reset_restart_tick", waited, DIV);

`ifndef SEQ_TIMEOUT_EN
        // Stall ADC_WAIT for ~310 periods: dropped ticks saturate at 255.
        run_seq(10'h0F0, 310 * DIV, 0, 10'h30F, 1'b0, waited, t_adc);
        check("overrun_saturate", overrun_cnt, 8'hFF);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
